// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic initiator.
// Holds the controller state encoding, default widths and a select-width helper.
package wb_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    function automatic int sel_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Clear/enable saturating cycle counter with a terminal-count flag.
// Ports: clk_i, rst_ni (async low), clr_i, en_i, tc_o (count == TIMEOUT-1).
module wb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Stops at TIMEOUT so a stalled enable can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone B4 classic initiator: one command in, one bus cycle, one response out.
// Ports: cmd_* request port, rsp_* response port, wbm_* bus side, busy status.
module wb_master_ctrl
    import wb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [AW-1:0]           cmd_adr,
    input  logic [DW-1:0]           cmd_dat,
    input  logic [sel_width(DW)-1:0] cmd_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DW-1:0]           rsp_dat,
    output logic                    rsp_err,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [sel_width(DW)-1:0] wbm_sel_o,
    output logic [AW-1:0]           wbm_adr_o,
    output logic [DW-1:0]           wbm_dat_o,
    input  logic                    wbm_ack_i,
    input  logic [DW-1:0]           wbm_dat_i,
    output logic                    busy
);

    localparam int SW = sel_width(DW);

    wb_state_e     state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [DW-1:0] rsp_dat_q, rsp_dat_d;
    logic          busy_q, busy_d;
    logic          tmo_tc;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_n_i),
        .clr_i  (state_q == ST_IDLE),
        .en_i   (state_q == ST_BUS),
        .tc_o   (tmo_tc)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_BUS;
                    cyc_d   = 1'b1;
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                end
            end
            ST_BUS: begin
                // Ack is checked first so a late ack on the last
                // allowed cycle still completes normally.
                if (wbm_ack_i) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                end else if (tmo_tc) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_dat   = rsp_dat_q;
    // Classic non-pipelined: strobe is asserted for the whole cycle.
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Directed bench for wb_master_ctrl with TIMEOUT=8.
// Vector table for single transactions plus backpressure and reset sequences.
module tb_wb_master_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic        ack = 1'b0;
    logic [31:0] dat_i = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    wb_master_ctrl #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_dat    (cmd_dat),
        .cmd_sel    (cmd_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_dat    (rsp_dat),
        .rsp_err    (rsp_err),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat_o),
        .wbm_ack_i  (ack),
        .wbm_dat_i  (dat_i),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;
        logic [31:0] rdat;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave: acks in stb cycle waits+1; waits beyond the limit never ack.
    task automatic run_bus(input int waits, input logic [31:0] rd,
                           output int n);
        n = 0;
        while (stb && n < 64) begin
            n++;
            chk("busy_in_bus", busy, 1);
            if (n == waits + 1) begin
                ack   = 1'b1;
                dat_i = rd;
            end else begin
                ack = 1'b0;
            end
            tick();
        end
        ack = 1'b0;
    endtask

    task automatic rsp_handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("rsp_err_clear", rsp_err, 0);
        chk("rsp_dat_clear", rsp_dat, 0);
        chk("busy_idle", busy, 0);
        chk("cmd_ready_idle", cmd_ready, 1);
    endtask

    task automatic do_txn(input vec_t v);
        int n;
        chk("cmd_ready_pre", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_sel   = v.sel;
        tick();
        cmd_valid = 1'b0;
        chk("stb_up", stb, 1);
        chk("cyc_up", cyc, 1);
        chk("cmd_ready_bus", cmd_ready, 0);
        chk("we", we, v.we);
        chk("adr", adr, v.adr);
        chk("dat_o", dat_o, v.dat);
        chk("sel", sel, v.sel);
        run_bus(v.waits, v.rdat, n);
        chk("stb_cycles", n, v.exp_cyc);
        chk("cyc_down", cyc, 0);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("rsp_dat", rsp_dat, v.exp_dat);
        chk("busy_resp", busy, 1);
        chk("adr_retained", adr, v.adr);
        rsp_handshake();
    endtask

    initial begin
        int n;
        int stbs;

        vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0,
                    32'h1111_1111, 32'h0, 1'b0, 1};
        vecs[1] = '{1'b0, 32'h1000_0000, 32'h0, 4'hF, 3,
                    32'h1234_5678, 32'h1234_5678, 1'b0, 4};
        vecs[2] = '{1'b0, 32'h2000_0010, 32'h0, 4'hF, 255,
                    32'hFFFF_FFFF, 32'h0, 1'b1, 8};
        vecs[3] = '{1'b0, 32'h2000_0020, 32'h0, 4'hF, 7,
                    32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 8};
        vecs[4] = '{1'b1, 32'h4000_0100, 32'h0BAD_CAFE, 4'h3, 2,
                    32'h7777_7777, 32'h0, 1'b0, 3};
        vecs[5] = '{1'b0, 32'h5000_0008, 32'h0, 4'h1, 6,
                    32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 7};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_dat", rsp_dat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_adr", adr, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i]);
        end

        // Stray ack while idle must be ignored.
        ack = 1'b1;
        tick();
        tick();
        ack = 1'b0;
        chk("stray_ack_rsp", rsp_valid, 0);
        chk("stray_ack_cyc", cyc, 0);

        // Backpressure with a second command waiting.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h6000_0000;
        cmd_sel   = 4'hF;
        tick();
        cmd_we  = 1'b1;
        cmd_adr = 32'h6000_0004;
        cmd_dat = 32'h0102_0304;
        chk("bp_adr1", adr, 32'h6000_0000);
        run_bus(0, 32'h5555_AAAA, n);
        stbs = n;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_dat", rsp_dat, 32'h5555_AAAA);
            chk("bp_rsp_err", rsp_err, 0);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_stb", stb, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_idle_ready", cmd_ready, 1);
        chk("bp_idle_stb", stb, 0);
        tick();
        cmd_valid = 1'b0;
        chk("bp_stb2", stb, 1);
        chk("bp_adr2", adr, 32'h6000_0004);
        chk("bp_we2", we, 1);
        run_bus(0, 32'h9999_9999, n);
        stbs += n;
        chk("bp_stb_total", stbs, 2);
        chk("bp_rsp2_dat", rsp_dat, 0);
        chk("bp_rsp2_valid", rsp_valid, 1);
        rsp_handshake();

        // Asynchronous reset two cycles into a wait-stated read.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h7000_0000;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("ar_pre_stb", stb, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_cyc", cyc, 0);
        chk("ar_stb", stb, 0);
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_cmd_ready", cmd_ready, 1);
        ack   = 1'b1;
        dat_i = 32'hBEEF_0000;
        tick();
        chk("ar_stray_rsp", rsp_valid, 0);
        tick();
        ack = 1'b0;
        chk("ar_stray_rsp2", rsp_valid, 0);
        chk("ar_stray_cyc", cyc, 0);
        chk("ar_stray_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
